// File: rtl/ddr_write_packer.sv
// ddr_write_packer: packs a narrow word stream into DDR beats and drives the DMA write port
module ddr_write_packer #(
  parameter int IN_W   = 64,
  parameter int DDR_W  = 512,
  parameter int ADDR_W = 27,
  parameter int LEN_W  = 27
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [IN_W-1:0]   s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  output logic              done,
  output logic              err,
  output logic              write_req,
  output logic [ADDR_W-1:0] write_start_addr,
  output logic [LEN_W-1:0]  write_length,
  output logic [DDR_W-1:0]  din,
  output logic              din_en,
  output logic              din_eop,
  input  logic              din_rdy,
  input  logic              write_done
);
  localparam int WPB = DDR_W / IN_W;
  localparam int IW  = WPB > 1 ? $clog2(WPB) : 1;
  typedef enum logic [1:0] {IDLE, REQ, STREAM, WAIT_DONE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic [DDR_W-1:0]  pack_q, pack_d, beat_q, beat_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              bv_q, bv_d, beop_q, beop_d, fin_q, fin_d, flag_q, flag_d;
  logic              done_q, done_d, err_q, err_d;
  logic              acc, close, last_beat;
  assign cmd_ready        = state_q == IDLE;
  assign write_req        = state_q == REQ;
  assign write_start_addr = addr_q;
  assign write_length     = len_q;
  assign din              = beat_q;
  assign din_en           = bv_q & din_rdy;
  assign din_eop          = din_en & beop_q;
  assign s_ready          = state_q == STREAM & !fin_q & (!bv_q | din_rdy);
  assign done             = done_q;
  assign err              = err_q;
  // packing, beat hand-off and command sequencing; cnt_q counts closed beats so eop is known at close time
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    pack_d    = pack_q;
    beat_d    = beat_q;
    idx_d     = idx_q;
    bv_d      = bv_q & !din_en;
    beop_d    = beop_q;
    fin_d     = fin_q;
    flag_d    = flag_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    acc       = s_valid & s_ready;
    last_beat = cnt_q + 1'b1 == len_q;
    close     = acc & (idx_q == IW'(WPB - 1) | s_last);
    if (acc) begin
      pack_d[idx_q*IN_W +: IN_W] = s_data;
      idx_d = idx_q + 1'b1;
    end
    if (close) begin
      beat_d = pack_d;
      bv_d   = 1'b1;
      beop_d = s_last | last_beat;
      fin_d  = s_last | last_beat;
      flag_d = s_last ^ last_beat;
      cnt_d  = cnt_q + 1'b1;
      pack_d = '0;
      idx_d  = '0;
    end
    case (state_q)
      IDLE: if (cmd_valid) begin
        if (cmd_len == '0) begin
          done_d = 1'b1;
          err_d  = 1'b1;
        end else begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          cnt_d   = '0;
          fin_d   = 1'b0;
          flag_d  = 1'b0;
          state_d = REQ;
        end
      end
      REQ:       state_d = STREAM;
      STREAM:    state_d = din_en & beop_q ? WAIT_DONE : STREAM;
      WAIT_DONE: if (write_done) begin
        done_d  = 1'b1;
        err_d   = flag_q;
        state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
  end
  // state register; reset drops any partial beat
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      pack_q  <= '0;
      beat_q  <= '0;
      idx_q   <= '0;
      bv_q    <= 1'b0;
      beop_q  <= 1'b0;
      fin_q   <= 1'b0;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      pack_q  <= pack_d;
      beat_q  <= beat_d;
      idx_q   <= idx_d;
      bv_q    <= bv_d;
      beop_q  <= beop_d;
      fin_q   <= fin_d;
      flag_q  <= flag_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
endmodule
